// File: rtl/alu_uart_interface.sv
// alu_uart_interface
//   Frames bytes coming from a UART RX FIFO into ALU operands and an opcode,
//   and pushes the ALU result into the UART TX FIFO. A frame is three RX
//   bytes: DATA_A, DATA_B, OP. Only the low NB_INTERFACE_OP bits of OP are
//   kept. Every frame produces one TX byte.
//
//   FIFO handshake: an RX byte is valid while i_interface_fiforx_EMPTY is 0,
//   and it is consumed on the rising edge where o_interface_fiforx_READ is 1.
//   A TX byte is accepted on the rising edge where o_interface_fifotx_WRITE
//   is 1. WRITE is only raised while i_interface_fifotx_FULL is 0, so every
//   asserted WRITE is a completed push.
//
//   Optional feature: define INTERFACE_TIMEOUT_EN to abort a partial frame
//   after TIMEOUT_CYCLES idle cycles waiting for DATA_B or OP. Without it the
//   block waits forever and o_interface_TIMEOUT is tied to 0.
//
// Ports
//   i_clk                        clock, rising edge
//   i_reset                      asynchronous reset, active low
//   i_interface_fiforx_EMPTY     RX FIFO empty flag
//   i_interface_fiforx_READDATA  RX FIFO head byte
//   i_interface_fifotx_FULL      TX FIFO full flag
//   i_interface_alu_RESULT       combinational ALU result
//   o_interface_fiforx_READ      RX FIFO pop strobe
//   o_interface_fifotx_WRITE     TX FIFO push strobe
//   o_interface_fifotx_WRITEDATA byte pushed to the TX FIFO
//   o_interface_alu_DATAA/B      registered ALU operands
//   o_interface_alu_OP           registered ALU opcode
//   o_interface_BUSY             frame in progress (state other than GET_A)
//   o_interface_TIMEOUT          one-cycle pulse when a partial frame is aborted
//   o_interface_state            current FSM state, for debug/observation
//                                (0 GET_A, 1 GET_B, 2 GET_OP, 3 EXEC, 4 SEND)
module alu_uart_interface #(
    parameter int NB_INTERFACE_DATA    = 8,
    parameter int NB_INTERFACE_OP      = 6,
    parameter int NB_INTERFACE_TIMEOUT = 16,
    parameter int TIMEOUT_CYCLES       = 50000
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_interface_fiforx_EMPTY,
    input  logic [NB_INTERFACE_DATA-1:0] i_interface_fiforx_READDATA,
    input  logic                         i_interface_fifotx_FULL,
    input  logic [NB_INTERFACE_DATA-1:0] i_interface_alu_RESULT,
    output logic                         o_interface_fiforx_READ,
    output logic                         o_interface_fifotx_WRITE,
    output logic [NB_INTERFACE_DATA-1:0] o_interface_fifotx_WRITEDATA,
    output logic [NB_INTERFACE_DATA-1:0] o_interface_alu_DATAA,
    output logic [NB_INTERFACE_DATA-1:0] o_interface_alu_DATAB,
    output logic [NB_INTERFACE_OP-1:0]   o_interface_alu_OP,
    output logic                         o_interface_BUSY,
    output logic                         o_interface_TIMEOUT,
    output logic [2:0]                   o_interface_state
);

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   read;
    logic   write;
    logic   busy;
    logic   timeout_hit;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_GET_A:  if (read) state_next = ST_GET_B;
            ST_GET_B: begin
                if (read)             state_next = ST_GET_OP;
                else if (timeout_hit) state_next = ST_GET_A;
            end
            ST_GET_OP: begin
                if (read)             state_next = ST_EXEC;
                else if (timeout_hit) state_next = ST_GET_A;
            end
            ST_EXEC:   state_next = ST_SEND;
            ST_SEND:   if (!i_interface_fifotx_FULL) state_next = ST_GET_A;
            default:   state_next = ST_GET_A;
        endcase
    end

    // Output logic. READ is gated by reset so that a non-empty RX FIFO does
    // not produce a pop strobe while the block is held in reset.
    always_comb begin
        read  = 1'b0;
        write = 1'b0;
        busy  = 1'b1;
        case (state)
            ST_GET_A: begin
                read = i_reset & ~i_interface_fiforx_EMPTY;
                busy = 1'b0;
            end
            ST_GET_B, ST_GET_OP: read = i_reset & ~i_interface_fiforx_EMPTY;
            ST_SEND:             write = ~i_interface_fifotx_FULL;
            default: ;
        endcase
    end

    assign o_interface_fiforx_READ  = read;
    assign o_interface_fifotx_WRITE = write;
    assign o_interface_BUSY         = busy;
    assign o_interface_state        = state;

    // Operand / opcode capture and result register. Each register only
    // changes when its own byte arrives, so values stay put until the next
    // frame overwrites them.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_interface_alu_DATAA        <= '0;
            o_interface_alu_DATAB        <= '0;
            o_interface_alu_OP           <= '0;
            o_interface_fifotx_WRITEDATA <= '0;
        end else begin
            if (read && state == ST_GET_A)  o_interface_alu_DATAA <= i_interface_fiforx_READDATA;
            if (read && state == ST_GET_B)  o_interface_alu_DATAB <= i_interface_fiforx_READDATA;
            if (read && state == ST_GET_OP) o_interface_alu_OP    <= i_interface_fiforx_READDATA[NB_INTERFACE_OP-1:0];
            if (state == ST_EXEC)           o_interface_fifotx_WRITEDATA <= i_interface_alu_RESULT;
        end
    end

`ifdef INTERFACE_TIMEOUT_EN
    localparam logic [NB_INTERFACE_TIMEOUT-1:0] TIMEOUT_LAST =
        NB_INTERFACE_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_INTERFACE_TIMEOUT-1:0] idle_cnt;
    logic                            timeout_q;
    logic                            waiting;

    // Only a stalled partial frame counts; any pop means the RX side is
    // alive, and EMPTY=0 in these states always pops.
    assign waiting     = (state == ST_GET_B || state == ST_GET_OP) && i_interface_fiforx_EMPTY;
    assign timeout_hit = waiting && (idle_cnt == TIMEOUT_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (!waiting || timeout_hit) idle_cnt <= '0;
            else                         idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign o_interface_TIMEOUT = timeout_q;
`else
    assign timeout_hit         = 1'b0;
    assign o_interface_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_alu_uart_interface.sv
module tb_alu_uart_interface;

`ifdef INTERFACE_TIMEOUT_EN
    localparam int TB_TIMEOUT = 20;
`else
    localparam int TB_TIMEOUT = 50000;
`endif

    // ---------------- clock / reset ----------------
    logic       i_clk = 1'b0;
    logic       i_reset;
    always #5 i_clk = ~i_clk;

    logic       rx_empty;
    logic [7:0] rx_data;
    logic       tx_full;
    logic [7:0] alu_result;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] dataa;
    logic [7:0] datab;
    logic [5:0] op;
    logic       busy;
    logic       tmo;
    logic [2:0] st;

    alu_uart_interface #(
        .NB_INTERFACE_DATA(8),
        .NB_INTERFACE_OP(6),
        .NB_INTERFACE_TIMEOUT(16),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_interface_fiforx_EMPTY(rx_empty),
        .i_interface_fiforx_READDATA(rx_data),
        .i_interface_fifotx_FULL(tx_full),
        .i_interface_alu_RESULT(alu_result),
        .o_interface_fiforx_READ(rd),
        .o_interface_fifotx_WRITE(wr),
        .o_interface_fifotx_WRITEDATA(wdata),
        .o_interface_alu_DATAA(dataa),
        .o_interface_alu_DATAB(datab),
        .o_interface_alu_OP(op),
        .o_interface_BUSY(busy),
        .o_interface_TIMEOUT(tmo),
        .o_interface_state(st)
    );

    // ---------------- reference ALU ----------------
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] o);
        case (o)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return $signed(a) >>> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_ref(dataa, datab, op);

    function automatic logic [7:0] rand_op_byte();
        logic [5:0] o;
        case ($urandom_range(0, 7))
            0: o = 6'h20; 1: o = 6'h22; 2: o = 6'h24; 3: o = 6'h25;
            4: o = 6'h26; 5: o = 6'h27; 6: o = 6'h02; default: o = 6'h03;
        endcase
        return {2'($urandom_range(0, 3)), o};
    endfunction

    // ---------------- FIFO models / scoreboard state ----------------
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         wr_cyc_q[$];
    int         cyc = 0;
    int         rd_count = 0;
    int         last_rd_cyc = 0;
    int         full_write_viol = 0;
    int         tmo_count = 0;
    int         tmo_cyc = 0;
    logic       tmo_busy = 1'b1;
    int         checks = 0;
    int         errors = 0;

    task automatic drive_rx();
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    endtask

    // One clock cycle: sample outputs mid-cycle, then apply the pops/pushes
    // the DUT made on the rising edge.
    task automatic tick();
        logic       s_rd;
        logic       s_wr;
        logic       s_full;
        logic [7:0] s_wd;
        @(negedge i_clk);
        s_rd = rd; s_wr = wr; s_full = tx_full; s_wd = wdata;
        if (s_wr && s_full) full_write_viol++;
        if (tmo) begin
            tmo_count++;
            tmo_cyc  = cyc;
            tmo_busy = busy;
        end
        @(posedge i_clk);
        #1;
        if (s_rd) begin
            rd_count++;
            last_rd_cyc = cyc;
            if (rx_q.size() > 0) void'(rx_q.pop_front());
        end
        if (s_wr && !s_full) begin
            got_q.push_back(s_wd);
            wr_cyc_q.push_back(cyc);
        end
        cyc++;
        drive_rx();
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(o);
        exp_q.push_back(alu_ref(a, b, o[5:0]));
        drive_rx();
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        while (got_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic clear_logs();
        got_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset = 1'b0;
        tx_full = 1'b0;
        rx_q.push_back(8'hAA);
        drive_rx();
        #3;
        checks++;
        if ({rd, wr, busy, tmo} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000", {rd, wr, busy, tmo});
        end
        checks++;
        if ({dataa, datab, op, wdata} !== 30'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {dataa, datab, op, wdata});
        end
        checks++;
        if (st !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", st);
        end
        tick();
        tick();
        checks++;
        if (rd_count !== 0 || rx_q.size() != 1) begin
            errors++; $display("FAIL reset_no_pop: reads %0d expected 0", rd_count);
        end
        rx_q.delete();
        drive_rx();
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        bit ok;
        int rd0;
        clear_logs();
        rd0 = rd_count;
        push_frame(8'h05, 8'h03, 8'h20);
        wait_writes(1, 20, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_write_seen: got 0 writes expected 1");
        end else begin
            checks++;
            if (got_q[0] !== 8'h08) begin
                errors++; $display("FAIL single_data: got %h expected 08", got_q[0]);
            end
            checks++;
            if (wr_cyc_q[0] - last_rd_cyc != 2) begin
                errors++; $display("FAIL single_latency: got %0d expected 2", wr_cyc_q[0] - last_rd_cyc);
            end
        end
        checks++;
        if ({dataa, datab, op} !== {8'h05, 8'h03, 6'h20}) begin
            errors++; $display("FAIL single_operands: got %h %h %h expected 05 03 20", dataa, datab, op);
        end
        repeat (4) tick();
        checks++;
        if (got_q.size() != 1 || rd_count - rd0 != 3) begin
            errors++; $display("FAIL single_counts: writes %0d reads %0d expected 1 3",
                               got_q.size(), rd_count - rd0);
        end
        checks++;
        if (busy !== 1'b0 || st !== 3'd0) begin
            errors++; $display("FAIL single_idle: busy %b state %0d expected 0 0", busy, st);
        end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        int         rd0;
        logic [7:0] e;
        clear_logs();
        rd0 = rd_count;
        for (int f = 0; f < 2; f++)
            push_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rand_op_byte());
        wait_writes(2, 40, ok);
        repeat (3) tick();
        checks++;
        if (!ok || got_q.size() != 2) begin
            errors++; $display("FAIL b2b_writes: got %0d expected 2", got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front();
                checks++;
                if (got_q[i] !== e) begin
                    errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], e);
                end
            end
            checks++;
            if (wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
                errors++; $display("FAIL b2b_spacing: got %0d expected 5", wr_cyc_q[1] - wr_cyc_q[0]);
            end
        end
        checks++;
        if (rd_count - rd0 != 6 || rx_q.size() != 0) begin
            errors++; $display("FAIL b2b_reads: got %0d expected 6", rd_count - rd0);
        end
    endtask

    task automatic test_tx_full();
        int         budget;
        int         n0;
        logic [7:0] e;
        clear_logs();
        tx_full = 1'b1;
        push_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rand_op_byte());
        e = exp_q[0];
        budget = 20;
        while (st !== 3'd4 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (st !== 3'd4) begin
            errors++; $display("FAIL full_reach_send: got state %0d expected 4", st);
        end
        n0 = full_write_viol;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (wdata !== e || st !== 3'd4) begin
                errors++; $display("FAIL full_hold%0d: got %h state %0d expected %h 4", i, wdata, st, e);
            end
        end
        checks++;
        if (got_q.size() != 0 || full_write_viol != n0) begin
            errors++; $display("FAIL full_no_write: got %0d writes expected 0", got_q.size() + full_write_viol - n0);
        end
        tx_full = 1'b0;
        tick();
        checks++;
        if (got_q.size() != 1 || wr_cyc_q[0] != cyc - 1) begin
            errors++; $display("FAIL full_release_write: got %0d writes expected 1 in first free cycle", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== e) begin
                errors++; $display("FAIL full_release_data: got %h expected %h", got_q[0], e);
            end
        end
        repeat (3) tick();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL full_single_write: got %0d expected 1", got_q.size());
        end
    endtask

    task automatic test_op_mask();
        bit         ok;
        logic [7:0] a;
        logic [7:0] b;
        clear_logs();
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        push_frame(a, b, 8'hE2);
        wait_writes(1, 20, ok);
        checks++;
        if (op !== 6'h22) begin
            errors++; $display("FAIL mask_op: got %h expected 22", op);
        end
        checks++;
        if (!ok || got_q[0] !== 8'(a - b)) begin
            errors++; $display("FAIL mask_result: got %0d writes expected data %h", got_q.size(), 8'(a - b));
        end
        repeat (6) tick();
        checks++;
        if ({dataa, datab, op} !== {a, b, 6'h22}) begin
            errors++; $display("FAIL mask_stable: got %h %h %h expected %h %h 22", dataa, datab, op, a, b);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int rd0;
        int budget;
        clear_logs();
        rd0 = rd_count;
        rx_q.push_back(8'($urandom_range(1, 255)));
        rx_q.push_back(8'($urandom_range(1, 255)));
        drive_rx();
        budget = 10;
        while (rd_count - rd0 < 2 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (st !== 3'd2) begin
            errors++; $display("FAIL midrst_setup: got state %0d expected 2", st);
        end
        i_reset = 1'b0;
        #2;
        checks++;
        if ({rd, wr, busy, tmo, dataa, datab, op, wdata, st} !== 37'h0) begin
            errors++; $display("FAIL midrst_outputs: got %h expected 0",
                               {rd, wr, busy, tmo, dataa, datab, op, wdata, st});
        end
        tick();
        tick();
        i_reset = 1'b1;
        repeat (10) tick();
        checks++;
        if (got_q.size() != 0 || st !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_no_write: writes %0d state %0d expected 0 0", got_q.size(), st);
        end
        push_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rand_op_byte());
        wait_writes(1, 20, ok);
        checks++;
        if (!ok || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL midrst_next_frame: got %0d writes expected data %h", got_q.size(), exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] pend_q[$];
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
        logic [7:0] e;
        int         frames;
        int         rd0;
        int         viol0;
        int         budget;
        bit         ok;
        clear_logs();
        frames = 25;
        rd0    = rd_count;
        viol0  = full_write_viol;
        for (int f = 0; f < frames; f++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            o = rand_op_byte();
            pend_q.push_back(a);
            pend_q.push_back(b);
            pend_q.push_back(o);
            exp_q.push_back(alu_ref(a, b, o[5:0]));
        end
        budget = 3000;
        while (got_q.size() < frames && budget > 0) begin
            if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                rx_q.push_back(pend_q.pop_front());
                drive_rx();
            end
            tx_full = ($urandom_range(0, 3) == 0);
            tick();
            budget--;
        end
        tx_full = 1'b0;
        wait_writes(frames, 20, ok);
        checks++;
        if (!ok || got_q.size() != frames) begin
            errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), frames);
        end
        for (int i = 0; i < frames && i < got_q.size(); i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin
                errors++; $display("FAIL rand_data%0d: got %h expected %h", i, got_q[i], e);
            end
        end
        checks++;
        if (rd_count - rd0 != 3 * frames || full_write_viol != viol0) begin
            errors++; $display("FAIL rand_strobes: reads %0d write_when_full %0d expected %0d 0",
                               rd_count - rd0, full_write_viol - viol0, 3 * frames);
        end
    endtask

`ifdef INTERFACE_TIMEOUT_EN
    task automatic test_timeout();
        bit         ok;
        int         rd0;
        int         t0;
        int         p;
        int         budget;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
        logic [7:0] e;
        clear_logs();
        rd0 = rd_count;
        t0  = tmo_count;
        rx_q.push_back(8'($urandom_range(0, 255)));
        drive_rx();
        budget = 10;
        while (rd_count == rd0 && budget > 0) begin
            tick();
            budget--;
        end
        p = last_rd_cyc;
        budget = 60;
        while (tmo_count == t0 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (tmo_count == t0) begin
            errors++; $display("FAIL timeout_pulse: got no pulse expected one");
        end else begin
            checks++;
            if (tmo_cyc - p < TB_TIMEOUT || tmo_cyc - p > TB_TIMEOUT + 1) begin
                errors++; $display("FAIL timeout_delay: got %0d expected %0d..%0d",
                                   tmo_cyc - p, TB_TIMEOUT, TB_TIMEOUT + 1);
            end
            checks++;
            if (tmo_busy !== 1'b0) begin
                errors++; $display("FAIL timeout_busy: got %b expected 0", tmo_busy);
            end
        end
        repeat (3) tick();
        checks++;
        if (tmo_count != t0 + 1 || st !== 3'd0) begin
            errors++; $display("FAIL timeout_single: pulses %0d state %0d expected 1 0", tmo_count - t0, st);
        end
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        o = rand_op_byte();
        push_frame(a, b, o);
        e = exp_q[0];
        wait_writes(1, 20, ok);
        checks++;
        if (!ok || got_q[0] !== e || dataa !== a) begin
            errors++; $display("FAIL timeout_next_frame: got A %h expected A %h data %h", dataa, a, e);
        end
    endtask
`else
    task automatic test_no_timeout();
        bit         ok;
        int         rd0;
        int         budget;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
        clear_logs();
        rd0 = rd_count;
        a = 8'($urandom_range(0, 255));
        rx_q.push_back(a);
        drive_rx();
        budget = 10;
        while (rd_count == rd0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (100) tick();
        checks++;
        if (tmo_count != 0 || st !== 3'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL no_timeout_wait: pulses %0d state %0d busy %b expected 0 1 1",
                               tmo_count, st, busy);
        end
        b = 8'($urandom_range(0, 255));
        o = rand_op_byte();
        rx_q.push_back(b);
        rx_q.push_back(o);
        exp_q.push_back(alu_ref(a, b, o[5:0]));
        drive_rx();
        wait_writes(1, 20, ok);
        checks++;
        if (!ok || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL no_timeout_frame: got %0d writes expected data %h", got_q.size(), exp_q[0]);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_tx_full();
        test_op_mask();
        test_reset_mid_frame();
        test_random();
`ifdef INTERFACE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_uart_interface.md
ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 The block SHALL have parameter NB_INTERFACE_DATA, default 8, giving the operand, result and FIFO byte width.
REQ-002 The block SHALL have parameter NB_INTERFACE_OP, default 6, giving the opcode width taken from the LSBs of the opcode byte.
REQ-003 The block SHALL have parameter NB_INTERFACE_TIMEOUT, default 16, giving the timeout counter width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the idle-cycle limit when timeout is compiled in.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_interface_fiforx_EMPTY, input, 1 bit: RX FIFO empty flag.
REQ-008 The block SHALL have port i_interface_fiforx_READDATA, input, NB_INTERFACE_DATA bits: RX FIFO head byte, valid while not empty.
REQ-009 The block SHALL have port i_interface_fifotx_FULL, input, 1 bit: TX FIFO full flag.
REQ-010 The block SHALL have port i_interface_alu_RESULT, input, NB_INTERFACE_DATA bits: combinational ALU result.
REQ-011 The block SHALL have port o_interface_fiforx_READ, output, 1 bit: RX FIFO pop strobe.
REQ-012 The block SHALL have port o_interface_fifotx_WRITE, output, 1 bit: TX FIFO push strobe.
REQ-013 The block SHALL have port o_interface_fifotx_WRITEDATA, output, NB_INTERFACE_DATA bits: byte pushed to the TX FIFO.
REQ-014 The block SHALL have ports o_interface_alu_DATAA and o_interface_alu_DATAB, outputs, NB_INTERFACE_DATA bits each: registered ALU operands.
REQ-015 The block SHALL have port o_interface_alu_OP, output, NB_INTERFACE_OP bits: registered ALU opcode.
REQ-016 The block SHALL have ports o_interface_BUSY and o_interface_TIMEOUT, outputs, 1 bit each: frame in progress; one-cycle frame-abort pulse.

Function
REQ-017 A frame SHALL be three RX bytes in the order DATA_A, DATA_B, OP; each frame SHALL produce one TX byte containing the result.
REQ-018 The FSM SHALL have states GET_A, GET_B, GET_OP, EXEC and SEND.
REQ-019 In states GET_A, GET_B and GET_OP, o_interface_fiforx_READ SHALL equal ~i_interface_fiforx_EMPTY (combinational), so at most one byte is popped per cycle.
REQ-020 On a pop, the head byte SHALL be registered into DATAA, DATAB or OP[NB_INTERFACE_OP-1:0] for the matching state, and the FSM SHALL advance to the next state on the same edge.
REQ-021 In state EXEC, the block SHALL register i_interface_alu_RESULT into o_interface_fifotx_WRITEDATA and go to SEND after exactly one cycle.
REQ-022 In state SEND with ~FULL, the block SHALL assert o_interface_fifotx_WRITE for exactly one cycle and return to GET_A.
REQ-023 In state SEND with FULL, the block SHALL hold in SEND with WRITE low and WRITEDATA stable.
REQ-024 Latency from the OP-byte pop to the TX write SHALL be 2 cycles when the TX FIFO is not full.
REQ-025 OP byte bits above NB_INTERFACE_OP SHALL be ignored.
REQ-026 Operands and opcode SHALL remain stable from capture until overwritten by the next frame.
REQ-027 o_interface_BUSY SHALL be 1 in every state except GET_A.
REQ-028 READ and WRITE SHALL never be asserted outside their respective states.

Reset
REQ-029 While i_reset is 0, the state SHALL be GET_A and all registers and outputs SHALL be 0, regardless of the clock.
REQ-030 On reset assertion mid-frame, the partial frame SHALL be discarded and no TX write SHALL follow.

Configuration
REQ-031 When INTERFACE_TIMEOUT_EN is defined, a counter SHALL count cycles spent in GET_B or GET_OP with EMPTY=1, and SHALL clear on every pop and in every other state.
REQ-032 When INTERFACE_TIMEOUT_EN is defined and the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to GET_A and pulse o_interface_TIMEOUT for one cycle.
REQ-033 When INTERFACE_TIMEOUT_EN is undefined, no counter SHALL exist, o_interface_TIMEOUT SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Verification
REQ-034 The bench SHALL cover a single frame: RX 0x05, 0x03, 0x20 with ALU=ADD model -> OP=0x20, one WRITE with data 0x08, 2 cycles after the OP pop.
REQ-035 The bench SHALL cover back-to-back frames: six bytes preloaded -> two writes in order, with exactly one READ pulse per byte.
REQ-036 The bench SHALL cover TX full: FULL=1 for 10 cycles in SEND -> WRITE low, data held, then one WRITE in the cycle after FULL falls.
REQ-037 The bench SHALL cover OP masking: OP byte 0xE2 -> o_interface_alu_OP=0x22.
REQ-038 The bench SHALL cover reset mid-frame: i_reset=0 after DATA_B -> outputs 0, state GET_A, and no write after release.
REQ-039 The bench SHALL cover timeout, with INTERFACE_TIMEOUT_EN and TIMEOUT_CYCLES=20: one byte then none -> TIMEOUT pulse, BUSY=0, and the next byte is taken as DATA_A.
